// File: rtl/axislv_ram_if.sv
// AXI4 burst bus between a CNN-engine master and the axislv_ram responder.
// Signal names carry the direction as seen from the responder (I_ = into it, O_ = out of it).
interface axislv_ram_if #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 128
);
    // read address / data
    logic [C_S_AXI_ID_WIDTH-1:0]     I_saxi_arid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_araddr;
    logic [7:0]                      I_saxi_arlen;
    logic                            I_saxi_arvalid;
    logic                            O_saxi_arready;
    logic [C_S_AXI_ID_WIDTH-1:0]     O_saxi_rid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   O_saxi_rdata;
    logic [1:0]                      O_saxi_rresp;
    logic                            O_saxi_rlast;
    logic                            O_saxi_rvalid;
    logic                            I_saxi_rready;
    // write address / data / response
    logic [C_S_AXI_ID_WIDTH-1:0]     I_saxi_awid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_awaddr;
    logic [7:0]                      I_saxi_awlen;
    logic                            I_saxi_awvalid;
    logic                            O_saxi_awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   I_saxi_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] I_saxi_wstrb;
    logic                            I_saxi_wlast;
    logic                            I_saxi_wvalid;
    logic                            O_saxi_wready;
    logic [C_S_AXI_ID_WIDTH-1:0]     O_saxi_bid;
    logic [1:0]                      O_saxi_bresp;
    logic                            O_saxi_bvalid;
    logic                            I_saxi_bready;

    modport slave (
        input  I_saxi_arid, I_saxi_araddr, I_saxi_arlen, I_saxi_arvalid, I_saxi_rready,
        input  I_saxi_awid, I_saxi_awaddr, I_saxi_awlen, I_saxi_awvalid,
        input  I_saxi_wdata, I_saxi_wstrb, I_saxi_wlast, I_saxi_wvalid, I_saxi_bready,
        output O_saxi_arready, O_saxi_rid, O_saxi_rdata, O_saxi_rresp, O_saxi_rlast, O_saxi_rvalid,
        output O_saxi_awready, O_saxi_wready, O_saxi_bid, O_saxi_bresp, O_saxi_bvalid
    );

    modport master (
        output I_saxi_arid, I_saxi_araddr, I_saxi_arlen, I_saxi_arvalid, I_saxi_rready,
        output I_saxi_awid, I_saxi_awaddr, I_saxi_awlen, I_saxi_awvalid,
        output I_saxi_wdata, I_saxi_wstrb, I_saxi_wlast, I_saxi_wvalid, I_saxi_bready,
        input  O_saxi_arready, O_saxi_rid, O_saxi_rdata, O_saxi_rresp, O_saxi_rlast, O_saxi_rvalid,
        input  O_saxi_awready, O_saxi_wready, O_saxi_bid, O_saxi_bresp, O_saxi_bvalid
    );
endinterface

// File: rtl/axislv_ram.sv
// AXI4 burst responder over a simple-dual-port RAM with registered, read-first read port.
// Read and write channels are independent FSMs, each with one outstanding burst.
module axislv_ram #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int ASIZE              = 10
) (
    input  logic         I_clk,
    input  logic         I_rst,
    axislv_ram_if.slave  saxi
);
    localparam int NSTRB   = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(NSTRB);
    localparam int DEPTH   = 2 ** ASIZE;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // ---------------------------------------------------------------- read side
    r_state_e                      r_state_q, r_state_d;
    logic                          arready_q;
    logic                          rvalid_q;
    logic                          rlast_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [ASIZE-1:0]              rd_idx_q;
    logic [8:0]                    rd_left_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_q;
    logic                          ar_hs;
    logic                          rd_en;

    assign ar_hs = saxi.I_saxi_arvalid && arready_q;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        r_state_d = r_state_q;
        rd_en     = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) r_state_d = R_FETCH;
            end
            R_FETCH: begin
                rd_en     = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                // the RAM output register doubles as the output stage: refill only when it drains
                rd_en = (rd_left_q != 9'd0) && (!rvalid_q || saxi.I_saxi_rready);
                if (rvalid_q && saxi.I_saxi_rready && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rd_idx_q  <= '0;
            rd_left_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            if (ar_hs) begin
                rid_q     <= saxi.I_saxi_arid;
                rd_idx_q  <= saxi.I_saxi_araddr[IDX_LSB +: ASIZE];
                rd_left_q <= {1'b0, saxi.I_saxi_arlen} + 9'd1;
            end else if (rd_en) begin
                rd_idx_q  <= rd_idx_q + ASIZE'(1);
                rd_left_q <= rd_left_q - 9'd1;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (rd_left_q == 9'd1);
            end else if (saxi.I_saxi_rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    // --------------------------------------------------------------- write side
    w_state_e                      w_state_q, w_state_d;
    logic                          awready_q;
    logic                          wready_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
    logic [ASIZE-1:0]              wr_idx_q;
    logic [8:0]                    wr_left_q;
    logic                          wr_err_q, wr_err_d;
    logic                          aw_hs;
    logic                          wr_en;

    assign aw_hs = saxi.I_saxi_awvalid && awready_q;

    always_comb begin
        w_state_d = w_state_q;
        wr_en     = 1'b0;
        wr_err_d  = wr_err_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    wr_err_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (saxi.I_saxi_wvalid && wready_q) begin
                    wr_en = 1'b1;
                    // the beat count ends the burst; wlast only has to agree with it
                    if (saxi.I_saxi_wlast != (wr_left_q == 9'd1)) wr_err_d = 1'b1;
                    if (wr_left_q == 9'd1) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (saxi.I_saxi_bready && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            wr_idx_q  <= '0;
            wr_left_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
            wr_err_q  <= wr_err_d;
            if (aw_hs) begin
                bid_q     <= saxi.I_saxi_awid;
                wr_idx_q  <= saxi.I_saxi_awaddr[IDX_LSB +: ASIZE];
                wr_left_q <= {1'b0, saxi.I_saxi_awlen} + 9'd1;
            end else if (wr_en) begin
                wr_idx_q  <= wr_idx_q + ASIZE'(1);
                wr_left_q <= wr_left_q - 9'd1;
            end
            if (w_state_q == W_DATA && w_state_d == W_RESP) begin
                bresp_q <= wr_err_d ? 2'b10 : 2'b00;
            end else if (w_state_q == W_RESP && w_state_d == W_IDLE) begin
                bresp_q <= 2'b00;
            end
        end
    end

    // --------------------------------------------------------------------- RAM
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array and its read register have no reset, so they map onto block RAM and keep contents across I_rst.
    always_ff @(posedge I_clk) begin
        for (int b = 0; b < NSTRB; b++) begin
            if (wr_en && saxi.I_saxi_wstrb[b]) begin
                mem_q[wr_idx_q][b*8 +: 8] <= saxi.I_saxi_wdata[b*8 +: 8];
            end
        end
        if (rd_en) rd_data_q <= mem_q[rd_idx_q];
    end

    // address bits outside the word index are ignored by design
    wire [C_S_AXI_ADDR_WIDTH-1:0] addr_unused = saxi.I_saxi_araddr ^ saxi.I_saxi_awaddr;

    assign saxi.O_saxi_arready = arready_q;
    assign saxi.O_saxi_rid     = rid_q;
    assign saxi.O_saxi_rdata   = rd_data_q;
    assign saxi.O_saxi_rresp   = 2'b00;
    assign saxi.O_saxi_rlast   = rlast_q;
    assign saxi.O_saxi_rvalid  = rvalid_q;
    assign saxi.O_saxi_awready = awready_q;
    assign saxi.O_saxi_wready  = wready_q;
    assign saxi.O_saxi_bid     = bid_q;
    assign saxi.O_saxi_bresp   = bresp_q;
    assign saxi.O_saxi_bvalid  = bvalid_q;
endmodule

// File: tb/tb_axislv_ram.sv
// Directed bench for axislv_ram: burst writes/reads, backpressure, strobes, wlast errors,
// index wrap, concurrent read/write collision and mid-burst reset.
module tb_axislv_ram;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [127:0] model [0:1023];
    logic [127:0] wdat  [0:255];
    logic [127:0] last_d;

    axislv_ram_if #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(128)) bus ();

    axislv_ram #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(128),
        .ASIZE             (10)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .saxi (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wlast_at: beat index driven with wlast=1 (-1 = never)
    task automatic write_burst(input string tag, input logic id, input logic [31:0] addr, input int len,
                               input logic [15:0] strb, input int wlast_at, input logic [1:0] exp_resp);
        int cyc;
        logic [9:0] idx;
        idx = addr[13:4];
        bus.I_saxi_awid    = id;
        bus.I_saxi_awaddr  = addr;
        bus.I_saxi_awlen   = 8'(len);
        bus.I_saxi_awvalid = 1'b1;
        cyc = 0;
        while (!bus.O_saxi_awready && cyc < 50) begin step(); cyc++; end
        check({tag, " awready"}, bus.O_saxi_awready, 1'b1);
        step();
        bus.I_saxi_awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            bus.I_saxi_wdata  = wdat[k];
            bus.I_saxi_wstrb  = strb;
            bus.I_saxi_wlast  = (k == wlast_at);
            bus.I_saxi_wvalid = 1'b1;
            cyc = 0;
            while (!bus.O_saxi_wready && cyc < 50) begin step(); cyc++; end
            if (!bus.O_saxi_wready) check({tag, " wready"}, bus.O_saxi_wready, 1'b1);
            step();
            for (int b = 0; b < 16; b++) begin
                if (strb[b]) model[idx + 10'(k)][b*8 +: 8] = wdat[k][b*8 +: 8];
            end
        end
        bus.I_saxi_wvalid = 1'b0;
        bus.I_saxi_wlast  = 1'b0;
        check({tag, " bvalid"}, bus.O_saxi_bvalid, 1'b1);
        check({tag, " bresp"},  bus.O_saxi_bresp,  exp_resp);
        check({tag, " bid"},    bus.O_saxi_bid,    id);
        bus.I_saxi_bready = 1'b1;
        step();
        bus.I_saxi_bready = 1'b0;
        check({tag, " bvalid drop"}, bus.O_saxi_bvalid, 1'b0);
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating
    task automatic read_burst(input string tag, input logic id, input logic [31:0] addr, input int len,
                              input int mode, output logic [127:0] last_beat);
        logic [127:0] exp_d [0:255];
        logic [127:0] held_d;
        logic         held_l, stall;
        logic [9:0]   idx;
        int cyc, got, first_cyc, gaps;
        idx = addr[13:4];
        for (int k = 0; k <= len; k++) exp_d[k] = model[idx + 10'(k)];
        last_beat = '0;
        bus.I_saxi_arid    = id;
        bus.I_saxi_araddr  = addr;
        bus.I_saxi_arlen   = 8'(len);
        bus.I_saxi_arvalid = 1'b1;
        cyc = 0;
        while (!bus.O_saxi_arready && cyc < 50) begin step(); cyc++; end
        check({tag, " arready"}, bus.O_saxi_arready, 1'b1);
        step();
        bus.I_saxi_arvalid = 1'b0;
        got = 0; cyc = 0; first_cyc = -1; gaps = 0; stall = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (got <= len && cyc < 500) begin
            bus.I_saxi_rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (stall) begin
                check({tag, " stall rvalid"}, bus.O_saxi_rvalid, 1'b1);
                check({tag, " stall rdata"},  bus.O_saxi_rdata,  held_d);
                check({tag, " stall rlast"},  bus.O_saxi_rlast,  held_l);
            end
            if (bus.O_saxi_rvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (bus.I_saxi_rready) begin
                    check($sformatf("%s rdata[%0d]", tag, got), bus.O_saxi_rdata, exp_d[got]);
                    check($sformatf("%s rlast[%0d]", tag, got), bus.O_saxi_rlast, (got == len));
                    check({tag, " rid"},   bus.O_saxi_rid,   id);
                    check({tag, " rresp"}, bus.O_saxi_rresp, 2'b00);
                    last_beat = bus.O_saxi_rdata;
                    got++;
                    stall = 1'b0;
                end else begin
                    stall  = 1'b1;
                    held_d = bus.O_saxi_rdata;
                    held_l = bus.O_saxi_rlast;
                end
            end else if (first_cyc >= 0) begin
                gaps++;
            end
            step();
            cyc++;
        end
        bus.I_saxi_rready = 1'b0;
        check({tag, " beats"},        got,       len + 1);
        check({tag, " first rvalid"}, first_cyc, 1);
        if (mode == 0) check({tag, " gaps"}, gaps, 0);
        check({tag, " rvalid idle"},  bus.O_saxi_rvalid,  1'b0);
        check({tag, " arready back"}, bus.O_saxi_arready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.I_saxi_arid = '0;    bus.I_saxi_araddr = '0;  bus.I_saxi_arlen = '0;
        bus.I_saxi_arvalid = 1'b0; bus.I_saxi_rready = 1'b0;
        bus.I_saxi_awid = '0;    bus.I_saxi_awaddr = '0;  bus.I_saxi_awlen = '0;
        bus.I_saxi_awvalid = 1'b0; bus.I_saxi_wdata = '0; bus.I_saxi_wstrb = '0;
        bus.I_saxi_wlast = 1'b0; bus.I_saxi_wvalid = 1'b0; bus.I_saxi_bready = 1'b0;

        // reset state
        #12;
        check("rst arready", bus.O_saxi_arready, 1'b0);
        check("rst awready", bus.O_saxi_awready, 1'b0);
        check("rst wready",  bus.O_saxi_wready,  1'b0);
        check("rst rvalid",  bus.O_saxi_rvalid,  1'b0);
        check("rst rlast",   bus.O_saxi_rlast,   1'b0);
        check("rst bvalid",  bus.O_saxi_bvalid,  1'b0);
        check("rst rid",     bus.O_saxi_rid,     1'b0);
        check("rst bid",     bus.O_saxi_bid,     1'b0);
        check("rst bresp",   bus.O_saxi_bresp,   2'b00);
        rst = 1'b0;
        step();
        check("post-rst arready", bus.O_saxi_arready, 1'b1);
        check("post-rst awready", bus.O_saxi_awready, 1'b1);
        check("post-rst wready",  bus.O_saxi_wready,  1'b0);

        // single write then read
        wdat[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
        write_burst("single wr", 1'b1, 32'h0000_0040, 0, 16'hFFFF, 0, 2'b00);
        read_burst("single rd", 1'b1, 32'h0000_0040, 0, 0, last_d);
        check("single data", last_d, 128'h0123456789ABCDEF0123456789ABCDEF);

        // 16-beat burst, full-rate read
        for (int k = 0; k < 16; k++) wdat[k] = {4{32'(k)}};
        write_burst("burst wr", 1'b0, 32'h0000_0100, 15, 16'hFFFF, 15, 2'b00);
        read_burst("burst rd", 1'b0, 32'h0000_0100, 15, 0, last_d);
        check("burst last data", last_d, {4{32'd15}});

        // read backpressure
        read_burst("bp rd", 1'b1, 32'h0000_0100, 7, 1, last_d);
        check("bp last data", last_d, {4{32'd7}});

        // byte strobes
        wdat[0] = {128{1'b1}};
        write_burst("strb wr1", 1'b0, 32'h0000_0200, 0, 16'hFFFF, 0, 2'b00);
        wdat[0] = '0;
        write_burst("strb wr2", 1'b0, 32'h0000_0200, 0, 16'h00FF, 0, 2'b00);
        read_burst("strb rd", 1'b0, 32'h0000_0200, 0, 0, last_d);
        check("strb data", last_d, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // wlast errors: early wlast, and missing wlast on a single beat
        for (int k = 0; k < 4; k++) wdat[k] = {4{32'hE000_0000 + 32'(k)}};
        write_burst("wlast early", 1'b1, 32'h0000_0300, 3, 16'hFFFF, 2, 2'b10);
        read_burst("wlast rd", 1'b1, 32'h0000_0300, 3, 0, last_d);
        check("wlast beat3 stored", last_d, {4{32'hE000_0003}});
        wdat[0] = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
        write_burst("wlast missing", 1'b0, 32'h0000_0400, 0, 16'hFFFF, -1, 2'b10);
        write_burst("after err ok", 1'b0, 32'h0000_0410, 0, 16'hFFFF, 0, 2'b00);

        // index wrap, upper address bits ignored
        wdat[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_03FF;
        wdat[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_0000;
        write_burst("wrap wr", 1'b1, 32'hFFFF_3FF0, 1, 16'hFFFF, 1, 2'b00);
        read_burst("wrap rd0", 1'b0, 32'h0000_0000, 0, 0, last_d);
        check("wrap idx0", last_d, 128'hBBBB_0000_0000_0000_0000_0000_0000_0000);
        read_burst("wrap rd", 1'b1, 32'h0000_3FF0, 1, 0, last_d);

        // concurrent read and write to the same words: read-first
        for (int k = 0; k < 4; k++) wdat[k] = {4{32'hC0DE_0000 + 32'(k)}};
        fork
            read_burst("conc rd", 1'b1, 32'h0000_0100, 3, 0, last_d);
            write_burst("conc wr", 1'b0, 32'h0000_0100, 3, 16'hFFFF, 3, 2'b00);
        join
        check("conc old data", last_d, {4{32'd3}});
        read_burst("conc after", 1'b0, 32'h0000_0100, 3, 0, last_d);
        check("conc new data", last_d, {4{32'hC0DE_0003}});

        // reset mid-read
        bus.I_saxi_arid    = 1'b1;
        bus.I_saxi_araddr  = 32'h0000_0100;
        bus.I_saxi_arlen   = 8'd7;
        bus.I_saxi_arvalid = 1'b1;
        bus.I_saxi_rready  = 1'b0;
        step();
        bus.I_saxi_arvalid = 1'b0;
        step();
        step();
        check("midrst rvalid before", bus.O_saxi_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst rvalid", bus.O_saxi_rvalid,  1'b0);
        check("midrst rlast",  bus.O_saxi_rlast,   1'b0);
        check("midrst rid",    bus.O_saxi_rid,     1'b0);
        check("midrst arready", bus.O_saxi_arready, 1'b0);
        #2;
        rst = 1'b0;
        step();
        read_burst("post-rst rd", 1'b0, 32'h0000_0100, 3, 0, last_d);
        check("post-rst data", last_d, {4{32'hC0DE_0003}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
